imem_boot_loader: RTL and testbench

Streams a program image into the pipeline's byte-addressed instruction memory over a valid/ready byte interface. It holds the CPU stalled until the image is written, padding the tail with zero bytes to a 4-byte boundary. It is the write-side counterpart of the instruction memory read port used by the fetch stage. It sits between an external byte source (UART or test harness) and the memory write port, and its `cpu_hold` output gates `PC_LE`/`IFID_LE` during boot.

---
 rtl/imem_boot_loader.sv | 128 ++++++++++++
 tb/tb_imem_boot_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a byte image into instruction memory, pads the tail to a
// word boundary and holds the CPU stalled until the image is complete.
module imem_boot_loader #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   byte_count
);

  // state  | meaning
  // LOAD   | accepting image bytes, one write per accepted byte
  // PAD    | writing 0x00 up to the next 4-byte boundary
  // FIN    | final write cycle plus settle cycles before releasing the CPU
  // DONE   | image written, CPU released
  // ERR    | image overflowed the memory, CPU held
  typedef enum logic [2:0] {S_LOAD, S_PAD, S_FIN, S_DONE, S_ERR} state_t;

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] WP_ONE    = (ADDR_W + 1)'(1);
  localparam logic [1:0]      FIN_LOAD  = 2'd2;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     wp_q, wp_d;
  logic [1:0]          fin_cnt_q, fin_cnt_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                accept;
  logic [ADDR_W-1:0]   wp_addr;

  assign wp_addr  = wp_q[ADDR_W-1:0];
  assign in_ready = (state_q == S_LOAD);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    fin_cnt_d   = fin_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wp_addr;
          mem_wdata_d = in_data;
          wp_d        = wp_q + WP_ONE;
          if (in_last) begin
            if (wp_addr[1:0] == 2'b11) begin
              state_d   = S_FIN;
              fin_cnt_d = FIN_LOAD;
            end else begin
              state_d = S_PAD;
            end
          end else if (wp_q == LAST_ADDR) begin
            // Last byte still lands in memory; the pointer never wraps.
            state_d = S_ERR;
          end
        end
      end
      S_PAD: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = wp_addr;
        mem_wdata_d = 8'h00;
        wp_d        = wp_q + WP_ONE;
        if (wp_addr[1:0] == 2'b11) begin
          state_d   = S_FIN;
          fin_cnt_d = FIN_LOAD;
        end
      end
      S_FIN: begin
        if (fin_cnt_q == 2'd0) begin
          state_d = S_DONE;
        end else begin
          fin_cnt_d = fin_cnt_q - 2'd1;
        end
      end
      S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LOAD;
          wp_d    = '0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_LOAD;
      wp_q        <= '0;
      fin_cnt_q   <= 2'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      fin_cnt_q   <= fin_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign byte_count = wp_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued at issue
// time and a negedge monitor compares every mem_we cycle against the queue.
module tb_imem_boot_loader;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   byte_count;

  imem_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .byte_count (byte_count)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wr_count = 0;
  int          last_edge = 0;
  logic [16:0] exp_q[$];
  logic [7:0]  img[DEPTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor: pops one expected {addr,data} per write strobe.
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n && mem_we) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          errors++;
          $display("FAIL write: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                   mem_addr, mem_wdata, e[16:8], e[7:0]);
        end
      end
    end
  end

  // Sends n bytes of img[]; gap_mod>0 inserts i%gap_mod idle cycles (with start
  // pulsed) before byte i. Expected writes, including pad bytes, are queued.
  task automatic send(input int n, input bit with_last, input int gap_mod);
    for (int i = 0; i < n; i++) begin
      if (gap_mod > 0) begin
        for (int g = 0; g < i % gap_mod; g++) begin
          start = 1'b1;
          @(posedge clk); #1;
        end
        start = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = img[i];
      in_last  = with_last && (i == n - 1);
      exp_q.push_back({9'(i), img[i]});
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      last_edge = cyc;
    end
    if (with_last) begin
      for (int a = n; a % 4 != 0; a++) exp_q.push_back({9'(a), 8'h00});
    end
  endtask

  task automatic wait_done(input string name, input int exp_delay);
    int k;
    k = 0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got done=0 expected done=1 within 40 cycles", name);
    end else begin
      check({name, "_delay"}, cyc - last_edge, exp_delay);
    end
    @(negedge clk); #1;
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic restart;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_in_ready", in_ready, 1);
    check("restart_count", byte_count, 0);
    check("restart_done", done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    #12;
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_count", byte_count, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // 8 bytes, no pad
    for (int i = 0; i < 8; i++) img[i] = 8'h10 + 8'(i);
    wr_count = 0;
    send(8, 1'b1, 0);
    check("img8_in_ready_low", in_ready, 0);
    wait_done("img8", 3);
    check("img8_count", byte_count, 8);
    check("img8_hold", cpu_hold, 0);
    check("img8_writes", wr_count, 8);

    // 5 bytes, 3 pad bytes
    restart();
    for (int i = 0; i < 5; i++) img[i] = 8'hA0 + 8'(i);
    send(5, 1'b1, 0);
    check("img5_in_ready_low", in_ready, 0);
    check("img5_hold_pad", cpu_hold, 1);
    wait_done("img5", 6);
    check("img5_count", byte_count, 8);

    // full 512-byte image, last at address 511
    restart();
    for (int i = 0; i < DEPTH; i++) img[i] = 8'(i * 7 + 3);
    send(DEPTH, 1'b1, 0);
    wait_done("img512", 3);
    check("img512_error", error, 0);
    check("img512_count", byte_count, 512);

    // overflow: byte at 511 without in_last
    restart();
    send(DEPTH, 1'b0, 0);
    check("ovf_error", error, 1);
    check("ovf_hold", cpu_hold, 1);
    check("ovf_in_ready", in_ready, 0);
    check("ovf_done", done, 0);
    @(negedge clk); #1;
    check("ovf_count", byte_count, 512);
    check("ovf_queue_empty", exp_q.size(), 0);
    restart();
    for (int i = 0; i < 4; i++) img[i] = 8'hC0 + 8'(i);
    send(4, 1'b1, 0);
    wait_done("ovf_reload", 3);
    check("ovf_reload_count", byte_count, 4);
    check("ovf_reload_error", error, 0);

    // async reset after 3 accepted bytes
    restart();
    for (int i = 0; i < 3; i++) img[i] = 8'h55 + 8'(i);
    send(3, 1'b0, 0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_we", mem_we, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_mem_wdata", mem_wdata, 0);
    check("mid_rst_count", byte_count, 0);
    check("mid_rst_hold", cpu_hold, 1);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    img[0] = 8'h24; img[1] = 8'h01; img[2] = 8'h00; img[3] = 8'h05;
    send(4, 1'b1, 0);
    wait_done("rst_reload", 3);
    check("rst_reload_count", byte_count, 4);

    // 12 bytes with idle gaps and ignored start pulses
    restart();
    for (int i = 0; i < 12; i++) img[i] = 8'h80 ^ 8'(i * 13);
    wr_count = 0;
    send(12, 1'b1, 3);
    wait_done("gap12", 3);
    check("gap12_writes", wr_count, 12);
    check("gap12_count", byte_count, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
